id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
// - ID->EX pipeline register of the 5-stage RV32I core: captures decoded ID fields and drives the EX operand muxes.
// - Detects load-use hazards; on a hazard it inserts a bubble itself.
// - Computes the one-hot EX forwarding selects for rs1 and rs2 from its registered source indices.
// PARAMETERS
// - DATA_WIDTH  32  width of PC, register data and immediate
// - REG_ADDR_W  5   register index width
// PORTS
// - clk                      in   1   rising-edge clock
// - rst_n                    in   1   synchronous reset, active low
// - stall_ID_EX              in   1   hold all registered outputs
// - flush_ID_EX              in   1   load a bubble (branch/jump redirect)
// - valid_ID                 in   1   ID holds a real instruction
// - PC_ID, RD1D_ID, RD2D_ID, imm_ID        in   DATA_WIDTH each   ID-stage data
// - rs1_ID, rs2_ID, rd_ID                  in   REG_ADDR_W each   register indices
// - alu_sel_rs1_ID           in   2   0=forwarded rs1, 1=PC, 2/3=zero
// - alu_sel_rs2_ID           in   1   0=forwarded rs2, 1=imm
// - alu_ctrl_ID              in   4   ALU opcode
// - reg_write_ID, mem_read_ID, mem_write_ID, branch_ID, jump_ID   in   1 each   control bits
// - result_src_ID            in   2   WB source select
// - <each ID input>_ID_EX_o  out  same width as input   registered copy (e.g. PC_ID_EX_o, RD1D_ID_EX_o)
// - valid_ID_EX_o            out  1   registered valid
// - rd_EX_MEM, reg_write_EX_MEM   in   5/1   EX/MEM destination
// - rd_MEM_WB, reg_write_MEM_WB   in   5/1   MEM/WB destination
// - forward_detect_EX_rs1    out  3   one-hot forward select for rs1
// - forward_detect_EX_rs2    out  3   one-hot forward select for rs2
// - load_use_hazard          out  1   to IF/PC and IF/ID: stall request
// BEHAVIOUR
// - Reset (rst_n==0 at posedge): every registered output becomes 0, so valid_ID_EX_o=0 and all control bits are 0.
// - Latency: 1 cycle from ID inputs to _ID_EX_o outputs.
// - Per-posedge priority: reset > flush_ID_EX > stall_ID_EX > load_use_hazard > capture.
//   - flush: load a bubble.
//   - stall: hold all registers.
//   - load_use_hazard: load a bubble.
//   - capture: load the ID inputs.
// - Bubble: every registered field is 0. This includes valid, reg_write, mem_*, branch, jump, rd and data.
// - Flush and stall together: flush wins; a bubble is loaded.
// - load_use_hazard is combinational:
//   - Asserted when valid_ID & mem_read_ID_EX_o & (rd_ID_EX_o != 0) & (rd_ID_EX_o == rs1_ID | rd_ID_EX_o == rs2_ID).
//   - It is not masked by flush; the upstream controller ignores it during a redirect.
// - Forwarding (combinational, from the registered rs1/rs2; shown for rsX):
//   - MEM (highest priority): rsX_ID_EX_o != 0 & reg_write_EX_MEM & rd_EX_MEM == rsX_ID_EX_o -> FORWARD_COLLISION_IN_MEM bit set.
//   - WB: otherwise, rsX_ID_EX_o != 0 & reg_write_MEM_WB & rd_MEM_WB == rsX_ID_EX_o -> FORWARD_COLLISION_IN_WB bit set.
//   - Otherwise: FORWARD_NO_COLLISION bit set.
//   - The output is exactly one-hot in every cycle, including after reset (NO_COLLISION).
// - x0 never forwards and never causes a hazard.
// - While valid_ID_EX_o==0 the forward output is don't-care but must still be one-hot.
// STRUCTURE
// - Shared define header holds:
//   - FORWARD_NO_COLLISION=0, FORWARD_COLLISION_IN_MEM=1, FORWARD_COLLISION_IN_WB=2 (bit indices);
//   - ALU_SEL_RS1_* codes;
//   - alu_ctrl opcode values.
// - Sub-module ex_forward_detect: combinational, one rs index in -> 3-bit one-hot out; instantiated twice (rs1, rs2).
// - The register bank and hazard compare live in the top module.
// TESTING
// - Reset: rst_n=0 for 2 cycles with random ID inputs.
//   -> all _ID_EX_o = 0, forward_detect_EX_rs1=3'b001, load_use_hazard=0.
// - Capture: ID PC=0x100, RD1D=0xA5, rd=3, reg_write=1, no stall.
//   -> next cycle PC_ID_EX_o=0x100, RD1D_ID_EX_o=0xA5, rd_ID_EX_o=3, valid=1.
// - Load-use: EX holds lw x5 (mem_read=1, rd=5); ID has add with rs2=5.
//   -> load_use_hazard=1; next cycle the register holds a bubble (valid=0, reg_write=0).
// - Forward priority: rs1_ID_EX_o=7, rd_EX_MEM=7 and rd_MEM_WB=7, both writes enabled.
//   -> 3'b010 (MEM). Clear reg_write_EX_MEM -> 3'b100 (WB).
// - x0: rs1_ID_EX_o=0 and rd_EX_MEM=0 with reg_write=1 -> 3'b001.
//   - EX lw x0 with rs1_ID=0 -> load_use_hazard=0.
// - Stall/flush: stall=1 for 3 cycles -> outputs frozen.
//   - stall=1 & flush=1 -> bubble.
//   - rst_n=0 during stall -> all outputs 0.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// rtl/id_ex_stage_reg_pkg.sv - shared forwarding indices, ALU select codes and ALU opcodes
package id_ex_stage_reg_pkg;

   // Bit positions inside the 3-bit one-hot forwarding select.
   localparam int FORWARD_NO_COLLISION     = 0;
   localparam int FORWARD_COLLISION_IN_MEM = 1;
   localparam int FORWARD_COLLISION_IN_WB  = 2;
   localparam int FWD_W                    = 3;

   // EX operand A select codes; both 2 and 3 select zero.
   localparam logic [1:0] ALU_SEL_RS1_REG  = 2'd0;
   localparam logic [1:0] ALU_SEL_RS1_PC   = 2'd1;
   localparam logic [1:0] ALU_SEL_RS1_ZERO = 2'd2;

   // EX operand B select codes.
   localparam logic ALU_SEL_RS2_REG = 1'b0;
   localparam logic ALU_SEL_RS2_IMM = 1'b1;

   // ALU opcodes carried through alu_ctrl.
   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_ctrl_e;

endpackage

// File: rtl/ex_forward_detect.sv
// rtl/ex_forward_detect.sv - one-hot EX forwarding select for a single source register
module ex_forward_detect
   import id_ex_stage_reg_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs_i,
   input  logic [REG_ADDR_W-1:0] rd_ex_mem_i,
   input  logic                  reg_write_ex_mem_i,
   input  logic [REG_ADDR_W-1:0] rd_mem_wb_i,
   input  logic                  reg_write_mem_wb_i,
   output logic [FWD_W-1:0]      forward_o
);

   // Youngest producer (EX/MEM) wins over MEM/WB; x0 never forwards.
   always_comb begin
      forward_o = '0;
      if ((rs_i != '0) && reg_write_ex_mem_i && (rd_ex_mem_i == rs_i)) begin
         forward_o[FORWARD_COLLISION_IN_MEM] = 1'b1;
      end else if ((rs_i != '0) && reg_write_mem_wb_i && (rd_mem_wb_i == rs_i)) begin
         forward_o[FORWARD_COLLISION_IN_WB] = 1'b1;
      end else begin
         forward_o[FORWARD_NO_COLLISION] = 1'b1;
      end
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use bubble and forwarding selects
module id_ex_stage_reg
   import id_ex_stage_reg_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall_ID_EX,
   input  logic                  flush_ID_EX,
   input  logic                  valid_ID,
   input  logic [DATA_WIDTH-1:0] PC_ID,
   input  logic [DATA_WIDTH-1:0] RD1D_ID,
   input  logic [DATA_WIDTH-1:0] RD2D_ID,
   input  logic [DATA_WIDTH-1:0] imm_ID,
   input  logic [REG_ADDR_W-1:0] rs1_ID,
   input  logic [REG_ADDR_W-1:0] rs2_ID,
   input  logic [REG_ADDR_W-1:0] rd_ID,
   input  logic [1:0]            alu_sel_rs1_ID,
   input  logic                  alu_sel_rs2_ID,
   input  logic [3:0]            alu_ctrl_ID,
   input  logic                  reg_write_ID,
   input  logic                  mem_read_ID,
   input  logic                  mem_write_ID,
   input  logic                  branch_ID,
   input  logic                  jump_ID,
   input  logic [1:0]            result_src_ID,
   output logic [DATA_WIDTH-1:0] PC_ID_EX_o,
   output logic [DATA_WIDTH-1:0] RD1D_ID_EX_o,
   output logic [DATA_WIDTH-1:0] RD2D_ID_EX_o,
   output logic [DATA_WIDTH-1:0] imm_ID_EX_o,
   output logic [REG_ADDR_W-1:0] rs1_ID_EX_o,
   output logic [REG_ADDR_W-1:0] rs2_ID_EX_o,
   output logic [REG_ADDR_W-1:0] rd_ID_EX_o,
   output logic [1:0]            alu_sel_rs1_ID_EX_o,
   output logic                  alu_sel_rs2_ID_EX_o,
   output logic [3:0]            alu_ctrl_ID_EX_o,
   output logic                  reg_write_ID_EX_o,
   output logic                  mem_read_ID_EX_o,
   output logic                  mem_write_ID_EX_o,
   output logic                  branch_ID_EX_o,
   output logic                  jump_ID_EX_o,
   output logic [1:0]            result_src_ID_EX_o,
   output logic                  valid_ID_EX_o,
   input  logic [REG_ADDR_W-1:0] rd_EX_MEM,
   input  logic                  reg_write_EX_MEM,
   input  logic [REG_ADDR_W-1:0] rd_MEM_WB,
   input  logic                  reg_write_MEM_WB,
   output logic [FWD_W-1:0]      forward_detect_EX_rs1,
   output logic [FWD_W-1:0]      forward_detect_EX_rs2,
   output logic                  load_use_hazard
);

   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] rd1d;
      logic [DATA_WIDTH-1:0] rd2d;
      logic [DATA_WIDTH-1:0] imm;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic [1:0]            alu_sel_rs1;
      logic                  alu_sel_rs2;
      logic [3:0]            alu_ctrl;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  branch;
      logic                  jump;
      logic [1:0]            result_src;
   } id_ex_t;

   id_ex_t id_in;
   id_ex_t ex_q;
   id_ex_t ex_d;

   // Gather the ID-stage fields into one bundle so a bubble is simply all zeros.
   always_comb begin
      id_in             = '0;
      id_in.valid       = valid_ID;
      id_in.pc          = PC_ID;
      id_in.rd1d        = RD1D_ID;
      id_in.rd2d        = RD2D_ID;
      id_in.imm         = imm_ID;
      id_in.rs1         = rs1_ID;
      id_in.rs2         = rs2_ID;
      id_in.rd          = rd_ID;
      id_in.alu_sel_rs1 = alu_sel_rs1_ID;
      id_in.alu_sel_rs2 = alu_sel_rs2_ID;
      id_in.alu_ctrl    = alu_ctrl_ID;
      id_in.reg_write   = reg_write_ID;
      id_in.mem_read    = mem_read_ID;
      id_in.mem_write   = mem_write_ID;
      id_in.branch      = branch_ID;
      id_in.jump        = jump_ID;
      id_in.result_src  = result_src_ID;
   end

   // A load in EX whose destination is read by the ID instruction cannot be forwarded in time.
   always_comb begin
      load_use_hazard = valid_ID && ex_q.mem_read && (ex_q.rd != '0) &&
                        ((ex_q.rd == rs1_ID) || (ex_q.rd == rs2_ID));
   end

   // Next state: flush beats stall, stall beats the self-inserted load-use bubble.
   always_comb begin
      ex_d = id_in;
      if (flush_ID_EX) begin
         ex_d = '0;
      end else if (stall_ID_EX) begin
         ex_d = ex_q;
      end else if (load_use_hazard) begin
         ex_d = '0;
      end
   end

   // Pipeline register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign PC_ID_EX_o          = ex_q.pc;
   assign RD1D_ID_EX_o        = ex_q.rd1d;
   assign RD2D_ID_EX_o        = ex_q.rd2d;
   assign imm_ID_EX_o         = ex_q.imm;
   assign rs1_ID_EX_o         = ex_q.rs1;
   assign rs2_ID_EX_o         = ex_q.rs2;
   assign rd_ID_EX_o          = ex_q.rd;
   assign alu_sel_rs1_ID_EX_o = ex_q.alu_sel_rs1;
   assign alu_sel_rs2_ID_EX_o = ex_q.alu_sel_rs2;
   assign alu_ctrl_ID_EX_o    = ex_q.alu_ctrl;
   assign reg_write_ID_EX_o   = ex_q.reg_write;
   assign mem_read_ID_EX_o    = ex_q.mem_read;
   assign mem_write_ID_EX_o   = ex_q.mem_write;
   assign branch_ID_EX_o      = ex_q.branch;
   assign jump_ID_EX_o        = ex_q.jump;
   assign result_src_ID_EX_o  = ex_q.result_src;
   assign valid_ID_EX_o       = ex_q.valid;

   ex_forward_detect #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
      .rs_i               (ex_q.rs1),
      .rd_ex_mem_i        (rd_EX_MEM),
      .reg_write_ex_mem_i (reg_write_EX_MEM),
      .rd_mem_wb_i        (rd_MEM_WB),
      .reg_write_mem_wb_i (reg_write_MEM_WB),
      .forward_o          (forward_detect_EX_rs1)
   );

   ex_forward_detect #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
      .rs_i               (ex_q.rs2),
      .rd_ex_mem_i        (rd_EX_MEM),
      .reg_write_ex_mem_i (reg_write_EX_MEM),
      .rd_mem_wb_i        (rd_MEM_WB),
      .reg_write_mem_wb_i (reg_write_MEM_WB),
      .forward_o          (forward_detect_EX_rs2)
   );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - directed self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

   logic        clk = 1'b0;
   logic        rst_n, stall_ID_EX, flush_ID_EX, valid_ID;
   logic [31:0] PC_ID, RD1D_ID, RD2D_ID, imm_ID;
   logic [4:0]  rs1_ID, rs2_ID, rd_ID;
   logic [1:0]  alu_sel_rs1_ID, result_src_ID;
   logic        alu_sel_rs2_ID;
   logic [3:0]  alu_ctrl_ID;
   logic        reg_write_ID, mem_read_ID, mem_write_ID, branch_ID, jump_ID;
   logic [31:0] PC_o, RD1D_o, RD2D_o, imm_o;
   logic [4:0]  rs1_o, rs2_o, rd_o;
   logic [1:0]  alu_sel_rs1_o, result_src_o;
   logic        alu_sel_rs2_o;
   logic [3:0]  alu_ctrl_o;
   logic        reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, valid_o;
   logic [4:0]  rd_EX_MEM, rd_MEM_WB;
   logic        reg_write_EX_MEM, reg_write_MEM_WB;
   logic [2:0]  fwd1, fwd2;
   logic        hazard;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage_reg dut (
      .clk(clk), .rst_n(rst_n), .stall_ID_EX(stall_ID_EX), .flush_ID_EX(flush_ID_EX),
      .valid_ID(valid_ID), .PC_ID(PC_ID), .RD1D_ID(RD1D_ID), .RD2D_ID(RD2D_ID), .imm_ID(imm_ID),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
      .alu_sel_rs1_ID(alu_sel_rs1_ID), .alu_sel_rs2_ID(alu_sel_rs2_ID), .alu_ctrl_ID(alu_ctrl_ID),
      .reg_write_ID(reg_write_ID), .mem_read_ID(mem_read_ID), .mem_write_ID(mem_write_ID),
      .branch_ID(branch_ID), .jump_ID(jump_ID), .result_src_ID(result_src_ID),
      .PC_ID_EX_o(PC_o), .RD1D_ID_EX_o(RD1D_o), .RD2D_ID_EX_o(RD2D_o), .imm_ID_EX_o(imm_o),
      .rs1_ID_EX_o(rs1_o), .rs2_ID_EX_o(rs2_o), .rd_ID_EX_o(rd_o),
      .alu_sel_rs1_ID_EX_o(alu_sel_rs1_o), .alu_sel_rs2_ID_EX_o(alu_sel_rs2_o),
      .alu_ctrl_ID_EX_o(alu_ctrl_o), .reg_write_ID_EX_o(reg_write_o),
      .mem_read_ID_EX_o(mem_read_o), .mem_write_ID_EX_o(mem_write_o),
      .branch_ID_EX_o(branch_o), .jump_ID_EX_o(jump_o), .result_src_ID_EX_o(result_src_o),
      .valid_ID_EX_o(valid_o),
      .rd_EX_MEM(rd_EX_MEM), .reg_write_EX_MEM(reg_write_EX_MEM),
      .rd_MEM_WB(rd_MEM_WB), .reg_write_MEM_WB(reg_write_MEM_WB),
      .forward_detect_EX_rs1(fwd1), .forward_detect_EX_rs2(fwd2),
      .load_use_hazard(hazard)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic id_idle();
      valid_ID = 0; PC_ID = 0; RD1D_ID = 0; RD2D_ID = 0; imm_ID = 0;
      rs1_ID = 0; rs2_ID = 0; rd_ID = 0; alu_sel_rs1_ID = 0; alu_sel_rs2_ID = 0;
      alu_ctrl_ID = 0; reg_write_ID = 0; mem_read_ID = 0; mem_write_ID = 0;
      branch_ID = 0; jump_ID = 0; result_src_ID = 0;
   endtask

   // Load a real instruction into ID.
   task automatic id_insn(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr);
      id_idle();
      valid_ID = 1; PC_ID = pc; rs1_ID = rs1; rs2_ID = rs2; rd_ID = rd;
      reg_write_ID = rw; mem_read_ID = mr;
   endtask

   initial begin
      stall_ID_EX = 0; flush_ID_EX = 0;
      rd_EX_MEM = 0; reg_write_EX_MEM = 0; rd_MEM_WB = 0; reg_write_MEM_WB = 0;
      // Reset with random ID inputs
      rst_n = 0;
      id_idle();
      valid_ID = 1; PC_ID = $urandom; RD1D_ID = $urandom; RD2D_ID = $urandom; imm_ID = $urandom;
      rs1_ID = 5'($urandom); rs2_ID = 5'($urandom); rd_ID = 5'($urandom);
      alu_ctrl_ID = 4'($urandom); reg_write_ID = 1; mem_read_ID = 1; mem_write_ID = 1;
      branch_ID = 1; jump_ID = 1; result_src_ID = 2'($urandom);
      @(negedge clk);
      tick();
      tick();
      check("rst_valid", 32'(valid_o), 0);
      check("rst_pc", PC_o, 0);
      check("rst_rd1d", RD1D_o, 0);
      check("rst_imm", imm_o, 0);
      check("rst_rd", 32'(rd_o), 0);
      check("rst_ctrl", {26'd0, reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, alu_sel_rs2_o}, 0);
      check("rst_fwd1", 32'(fwd1), 32'h1);
      check("rst_fwd2", 32'(fwd2), 32'h1);
      check("rst_hazard", 32'(hazard), 0);
      rst_n = 1;

      // Capture
      id_insn(32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      RD1D_ID = 32'hA5;
      tick();
      check("cap_pc", PC_o, 32'h100);
      check("cap_rd1d", RD1D_o, 32'hA5);
      check("cap_rd", 32'(rd_o), 3);
      check("cap_valid", 32'(valid_o), 1);
      check("cap_rw", 32'(reg_write_o), 1);

      // Load-use: lw x5 in EX, add reads x5 as rs2
      id_insn(32'h104, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
      tick();
      id_insn(32'h108, 5'd6, 5'd5, 5'd7, 1'b1, 1'b0);
      #1;
      check("lu_hazard", 32'(hazard), 1);
      @(negedge clk);
      check("lu_bubble_valid", 32'(valid_o), 0);
      check("lu_bubble_rw", 32'(reg_write_o), 0);
      check("lu_bubble_rd", 32'(rd_o), 0);
      check("lu_bubble_pc", PC_o, 0);
      check("lu_hazard_clr", 32'(hazard), 0);
      // ID without valid never raises a hazard
      id_insn(32'h10C, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
      tick();
      id_insn(32'h110, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0);
      valid_ID = 0;
      #1;
      check("lu_invalid_id", 32'(hazard), 0);
      // rs1 match also raises the hazard; stall overrides the bubble
      valid_ID = 1;
      #1;
      check("lu_rs1", 32'(hazard), 1);
      stall_ID_EX = 1;
      @(negedge clk);
      check("lu_stall_hold_rd", 32'(rd_o), 5);
      check("lu_stall_hold_v", 32'(valid_o), 1);
      stall_ID_EX = 0;

      // Forward priority on rs1=7
      id_insn(32'h200, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
      tick();
      rd_EX_MEM = 7; reg_write_EX_MEM = 1; rd_MEM_WB = 7; reg_write_MEM_WB = 1;
      #1;
      check("fwd_mem", 32'(fwd1), 32'h2);
      check("fwd_rs2_x0", 32'(fwd2), 32'h1);
      reg_write_EX_MEM = 0;
      #1;
      check("fwd_wb", 32'(fwd1), 32'h4);
      reg_write_MEM_WB = 0;
      #1;
      check("fwd_none", 32'(fwd1), 32'h1);
      rd_EX_MEM = 3; reg_write_EX_MEM = 1;
      #1;
      check("fwd_mem_other_rd", 32'(fwd1), 32'h1);

      // x0 never forwards, lw x0 never hazards
      @(negedge clk);
      id_insn(32'h300, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      tick();
      rd_EX_MEM = 0; reg_write_EX_MEM = 1; rd_MEM_WB = 0; reg_write_MEM_WB = 1;
      #1;
      check("x0_fwd1", 32'(fwd1), 32'h1);
      check("x0_fwd2", 32'(fwd2), 32'h1);
      id_insn(32'h304, 5'd0, 5'd4, 5'd1, 1'b1, 1'b0);
      #1;
      check("x0_hazard", 32'(hazard), 0);
      reg_write_EX_MEM = 0; reg_write_MEM_WB = 0;

      // Stall for 3 cycles
      @(negedge clk);
      id_insn(32'h400, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
      RD2D_ID = 32'h1234;
      tick();
      stall_ID_EX = 1;
      id_insn(32'h500, 5'd3, 5'd4, 5'd10, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc", PC_o, 32'h400);
         check("stall_rd", 32'(rd_o), 9);
         check("stall_rd2d", RD2D_o, 32'h1234);
      end
      // Stall and flush together
      flush_ID_EX = 1;
      tick();
      check("sf_valid", 32'(valid_o), 0);
      check("sf_pc", PC_o, 0);
      check("sf_rw", 32'(reg_write_o), 0);
      flush_ID_EX = 0;
      stall_ID_EX = 0;
      // Reset during stall
      id_insn(32'h600, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0);
      tick();
      check("pre_rst_pc", PC_o, 32'h600);
      stall_ID_EX = 1;
      rst_n = 0;
      tick();
      check("stall_rst_pc", PC_o, 0);
      check("stall_rst_valid", 32'(valid_o), 0);
      check("stall_rst_rd", 32'(rd_o), 0);
      rst_n = 1;
      stall_ID_EX = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
